// File: rtl/fingertip_pkg.sv
// Shared types and constants for the fingertip scanner: FSM encoding, edge sentinel and
// default raster size.
package fingertip_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLearn,
    StDetect
  } fsm_state_e;

  // Edge value for rows with no foreground yet, and for neighbour rows off the frame
  localparam logic [9:0] EDGE_MAX = 10'h3ff;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

endpackage

// File: rtl/fingertip_edge_buf.sv
// Per-row leftmost-foreground store: one write port, NPORT combinational read ports.
// Read addresses are 12-bit two's complement; anything off the frame reads EDGE_MAX.
module fingertip_edge_buf
  import fingertip_pkg::*;
#(
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned NPORT    = 9
) (
  input  logic                   vga_clk,
  input  logic                   we,
  input  logic [9:0]             waddr,
  input  logic [9:0]             wdata,
  input  logic [NPORT-1:0][11:0] raddr,
  output logic [NPORT-1:0][9:0]  rdata
);

  localparam int unsigned AW = $clog2(V_ACTIVE);

  // No reset: every row is rewritten during LEARN before DETECT reads it
  logic [9:0] mem [V_ACTIVE];

  always_ff @(posedge vga_clk) begin
    if (we && ({1'b0, waddr} < 11'(V_ACTIVE))) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NPORT); i++) begin
      rdata[i] = EDGE_MAX;
      if (!raddr[i][11] && (raddr[i] < 12'(V_ACTIVE))) begin
        rdata[i] = mem[raddr[i][AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/fingertip_scan.sv
// Counts fingertips in a binarised hand image: learn the leftmost edge per row in one frame,
// detect local edge minima in the next. Define FINGERTIP_OVERLAY_EN for the debug overlay.
module fingertip_scan
  import fingertip_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned NBR_STEP = 5,
  parameter int unsigned NBR_TAPS = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic [PIX_W-1:0] img_data,
  input  logic [9:0]       left,
  input  logic [9:0]       right,
  input  logic [9:0]       top,
  input  logic [9:0]       bottom,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             count_drop,
  input  logic [1:0]       mode,
  output logic [PIX_W-1:0] out_data
);

  localparam int unsigned NPORT = 2 * NBR_TAPS + 1;

  fsm_state_e state_q, state_d;
  logic       is_learn, is_detect, enter_detect, report;

  logic eof, fg, in_box, box_ok, region_ok, taps_ok, cand, accept;
  logic [10:0] mid;

  logic                   we;
  logic [9:0]             wdata;
  logic [NPORT-1:0][11:0] raddr;
  logic [NPORT-1:0][9:0]  rdata;
  logic [9:0]             edge_c;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       hist0_q, hist0_d, hist1_q, hist1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d, drop_q, drop_d;
  logic [PIX_W-1:0] out_q, out_d;

  assign eof    = (pixel_x == 10'(H_ACTIVE - 1)) && (pixel_y == 10'(V_ACTIVE - 1));
  assign fg     = &img_data;
  assign in_box = (left < pixel_x) && (pixel_x < right) && (top < pixel_y) && (pixel_y < bottom);

  // FSM: state register
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state, only ever moves at end of frame
  always_comb begin
    state_d = state_q;
    if (eof) begin
      case (state_q)
        StIdle:   state_d = en ? StLearn : StIdle;
        StLearn:  state_d = StDetect;
        StDetect: state_d = en ? StLearn : StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM: decoded outputs
  always_comb begin
    is_learn  = 1'b0;
    is_detect = 1'b0;
    case (state_q)
      StLearn:  is_learn = 1'b1;
      StDetect: is_detect = 1'b1;
      default:  ;
    endcase
    enter_detect = is_learn && eof;
    report       = is_detect && eof;
  end

  // Tap 0 is this row, 1..N are rows below, N+1..2N rows above
  always_comb begin
    raddr[0] = {2'b00, pixel_y};
    for (int k = 1; k <= int'(NBR_TAPS); k++) begin
      raddr[k]            = {2'b00, pixel_y} + 12'(k * NBR_STEP);
      raddr[NBR_TAPS + k] = {2'b00, pixel_y} - 12'(k * NBR_STEP);
    end
  end

  fingertip_edge_buf #(
    .V_ACTIVE (V_ACTIVE),
    .NPORT    (NPORT)
  ) u_edge_buf (
    .vga_clk (vga_clk),
    .we      (we),
    .waddr   (pixel_y),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rdata)
  );

  assign edge_c = rdata[0];
  assign we     = is_learn && ((pixel_x == '0) || (fg && in_box && (pixel_x < edge_c)));
  assign wdata  = (pixel_x == '0) ? EDGE_MAX : pixel_x;

  assign box_ok    = right > left;
  assign mid       = {1'b0, left} + (({1'b0, right} - {1'b0, left}) >> 1);
  // Left of centre is a finger; the thumb only counts once four fingers are in
  assign region_ok = box_ok && (({1'b0, pixel_x} < mid) ||
                                ((cnt_q == CNT_W'(4)) && ({1'b0, pixel_x} >= mid + 11'd10)));

  always_comb begin
    taps_ok = 1'b1;
    for (int k = 1; k <= int'(NBR_TAPS); k++) begin
      if (!(edge_c < rdata[k])) taps_ok = 1'b0;
      if (!(edge_c <= rdata[NBR_TAPS + k])) taps_ok = 1'b0;
    end
  end

  assign cand   = is_detect && fg && in_box && (pixel_x == edge_c) && region_ok && taps_ok;
  assign accept = cand && (pixel_x != hist0_q) && (pixel_x != hist1_q);

  always_comb begin
    cnt_d   = cnt_q;
    hist0_d = hist0_q;
    hist1_d = hist1_q;
    if (enter_detect) begin
      cnt_d   = '0;
      hist0_d = EDGE_MAX;
      hist1_d = EDGE_MAX;
    end else if (accept) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      hist1_d = hist0_q;
      hist0_d = pixel_x;
    end
  end

  // Report handshake: a new report always wins; it is a drop only if nobody took the old one
  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    drop_d  = 1'b0;
    if (report) begin
      count_d = cnt_d;
      valid_d = 1'b1;
      drop_d  = valid_q && !count_ready;
    end else if (valid_q && count_ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef FINGERTIP_OVERLAY_EN
  always_comb begin
    out_d = out_q;
    unique case (mode)
      2'b00: out_d = img_data;
      2'b01: out_d = (is_detect && (pixel_x == edge_c)) ? '1 : '0;
      2'b11: out_d = cand ? '1 : '0;
      2'b10: out_d = out_q;
    endcase
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign out_d       = img_data;
`endif

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      cnt_q   <= '0;
      hist0_q <= EDGE_MAX;
      hist1_q <= EDGE_MAX;
      count_q <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
      count_q <= count_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      out_q   <= out_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign count_drop  = drop_q;
  assign out_data    = out_q;

endmodule

// File: tb/tb_fingertip_scan.sv
// Directed bench for fingertip_scan: sparse rasters visit x=0 of every row plus the listed
// foreground pixels, then the end-of-frame pixel.
module tb_fingertip_scan;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int PW = 12;
  localparam int CW = 4;

  logic          vga_clk = 1'b0;
  logic          rst, en, count_ready, count_valid, count_drop;
  logic [9:0]    pixel_x, pixel_y, left, right, top, bottom;
  logic [PW-1:0] img_data, out_data;
  logic [CW-1:0] count;
  logic [1:0]    mode;

  int n_total;
  int n_bad;
  int img_row[$];
  int img_x[$];

  always #5 vga_clk = ~vga_clk;

  fingertip_scan #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .PIX_W    (PW),
    .NBR_STEP (5),
    .NBR_TAPS (4),
    .CNT_W    (CW)
  ) dut (
    .vga_clk     (vga_clk),
    .rst         (rst),
    .en          (en),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .img_data    (img_data),
    .left        (left),
    .right       (right),
    .top         (top),
    .bottom      (bottom),
    .count       (count),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .count_drop  (count_drop),
    .mode        (mode),
    .out_data    (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic px(input int x, input int y, input logic f);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    img_data = f ? '1 : '0;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic scan_rows(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      px(0, y, 1'b0);
      for (int i = 0; i < img_row.size(); i++) begin
        if (img_row[i] == y) px(img_x[i], y, 1'b1);
      end
    end
  endtask

  task automatic eof_px();
    px(H - 1, V - 1, 1'b0);
  endtask

  task automatic frame_chk(input string tag, input logic ev, input int ec);
    scan_rows(0, V - 1);
    eof_px();
    chk({tag, "_valid"}, 32'(count_valid), 32'(ev));
    if (ev) chk({tag, "_count"}, 32'(count), 32'(ec));
  endtask

  task automatic img_clear();
    img_row.delete();
    img_x.delete();
  endtask

  task automatic img_add(input int r, input int x);
    img_row.push_back(r);
    img_x.push_back(x);
  endtask

  task automatic set_box(input int l, input int r, input int t, input int b);
    left   = 10'(l);
    right  = 10'(r);
    top    = 10'(t);
    bottom = 10'(b);
  endtask

  task automatic img_a();
    img_clear();
    img_add(150, 100);
    img_add(200, 120);
    img_add(250, 140);
  endtask

  task automatic img_b();
    img_clear();
    img_add(150, 100);
    img_add(200, 120);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected test done");
    $fatal(1);
  end

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b1;
    en          = 1'b1;
    count_ready = 1'b1;
    mode        = 2'b00;
    pixel_x     = '0;
    pixel_y     = '0;
    img_data    = '0;
    set_box(50, 400, 50, 400);

    // Reset, with foreground on the input to show out_data is held low
    px(0, 0, 1'b1);
    px(0, 0, 1'b1);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(count_valid), 0);
    chk("rst_drop", 32'(count_drop), 0);
    chk("rst_out", 32'(out_data), 0);
    rst = 1'b0;
    px(5, 5, 1'b1);
    chk("out_fg", 32'(out_data), 32'hfff);
    px(6, 5, 1'b0);
    chk("out_bg", 32'(out_data), 0);

    // Three fingertips: idle -> learn -> detect, report one cycle after detect EOF
    img_a();
    frame_chk("t1_idle", 1'b0, 0);
    frame_chk("t1_learn", 1'b0, 0);
    frame_chk("t1_detect", 1'b1, 3);
    chk("t1_drop", 32'(count_drop), 0);
    px(0, 0, 1'b0);
    chk("t1_ack", 32'(count_valid), 0);
    chk("t1_hold", 32'(count), 3);

    // Two reports with no ready: second overwrites and drops once
    count_ready = 1'b0;
    frame_chk("t2_learn_a", 1'b0, 0);
    frame_chk("t2_detect_a", 1'b1, 3);
    chk("t2_drop_a", 32'(count_drop), 0);
    img_b();
    frame_chk("t2_learn_b", 1'b1, 3);
    frame_chk("t2_detect_b", 1'b1, 2);
    chk("t2_drop_b", 32'(count_drop), 1);
    px(0, 0, 1'b0);
    chk("t2_drop_pulse", 32'(count_drop), 0);
    chk("t2_pending", 32'(count_valid), 1);
    count_ready = 1'b1;
    px(0, 0, 1'b0);
    chk("t2_ack", 32'(count_valid), 0);

    // Rows near top and bottom: off-frame taps read EDGE_MAX, no wrap onto row 478
    set_box(0, 479, 0, 479);
    img_clear();
    img_add(8, 100);
    img_add(470, 110);
    img_add(478, 90);
    frame_chk("t3_learn", 1'b0, 0);
    frame_chk("t3_detect", 1'b1, 3);

    // Two-deep dedup history: 60,70,60(dup),80,90,60 -> five
    img_clear();
    img_add(100, 60);
    img_add(130, 70);
    img_add(160, 60);
    img_add(190, 80);
    img_add(220, 90);
    img_add(250, 60);
    frame_chk("t4_learn", 1'b0, 0);
    frame_chk("t4_detect", 1'b1, 5);

    // Thumb right of mid+10 only counts once four fingers are in (mid=239)
    img_clear();
    img_add(50, 300);
    img_add(100, 60);
    img_add(130, 70);
    img_add(160, 80);
    img_add(190, 90);
    img_add(250, 300);
    frame_chk("t5_learn", 1'b0, 0);
    frame_chk("t5_detect", 1'b1, 5);

    // Twenty distinct minima saturate at 15
    img_clear();
    for (int i = 0; i < 20; i++) img_add(10 + 21 * i, 20 + 5 * i);
    frame_chk("t6_learn", 1'b0, 0);
    count_ready = 1'b0;
    frame_chk("t6_detect", 1'b1, 15);

    // Plateau of three rows counts once; ready lands in the report cycle -> no drop
    img_clear();
    img_add(300, 200);
    img_add(301, 200);
    img_add(302, 200);
    frame_chk("t7_learn", 1'b1, 15);
    scan_rows(0, V - 1);
    count_ready = 1'b1;
    eof_px();
    chk("t7_valid", 32'(count_valid), 1);
    chk("t7_count", 32'(count), 1);
    chk("t7_drop", 32'(count_drop), 0);
    px(0, 0, 1'b0);
    chk("t7_ack", 32'(count_valid), 0);

    // Reset in the middle of a detect frame
    count_ready = 1'b0;
    set_box(50, 400, 50, 400);
    img_a();
    frame_chk("t8_learn", 1'b0, 0);
    frame_chk("t8_detect", 1'b1, 3);
    frame_chk("t8_learn2", 1'b1, 3);
    scan_rows(0, 200);
    rst = 1'b1;
    px(0, 201, 1'b0);
    chk("t8_rst_valid", 32'(count_valid), 0);
    chk("t8_rst_count", 32'(count), 0);
    rst = 1'b0;
    scan_rows(202, V - 1);
    eof_px();
    chk("t8_partial", 32'(count_valid), 0);
    frame_chk("t8_relearn", 1'b0, 0);
    frame_chk("t8_redetect", 1'b1, 3);

    // en dropped mid-detect: frame finishes and reports, then FSM idles
    count_ready = 1'b1;
    img_b();
    px(0, 0, 1'b0);
    chk("t9_ack", 32'(count_valid), 0);
    frame_chk("t9_learn", 1'b0, 0);
    scan_rows(0, 99);
    en = 1'b0;
    scan_rows(100, V - 1);
    eof_px();
    chk("t9_detect_valid", 32'(count_valid), 1);
    chk("t9_detect_count", 32'(count), 2);
    frame_chk("t9_idle_off", 1'b0, 0);
    en = 1'b1;
    frame_chk("t9_idle_on", 1'b0, 0);
    frame_chk("t9_learn2", 1'b0, 0);
    frame_chk("t9_detect2", 1'b1, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
